// File: rtl/pipe_pkg.sv
// Shared phase encoding and divider width for the pipeline sequencer.
// Types and helpers only; no latency, no backpressure.
package pipe_pkg;

   localparam int DIV_W = 8;

   typedef enum logic [1:0] {
      PH_SCAN   = 2'd0,
      PH_ADV    = 2'd1,
      PH_WB     = 2'd2,
      PH_SETTLE = 2'd3
   } phase_t;

   // Fixed ADV -> WB -> SETTLE -> SCAN chain; leaving SCAN is decided by the trigger.
   function automatic phase_t seq_next(input phase_t p);
      case (p)
         PH_ADV:  seq_next = PH_WB;
         PH_WB:   seq_next = PH_SETTLE;
         default: seq_next = PH_SCAN;
      endcase
   endfunction

endpackage

// File: rtl/div_strobe.sv
// Free-run divider: tick is a registered one-cycle strobe the cycle after div_cnt hits DIV_MAX.
// Latency one cycle from terminal count; pause holds the count at 0 and kills the strobe.
module div_strobe
   import pipe_pkg::*;
#(
   parameter int DIV_MAX = 63
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pause,
   output logic tick
);

   localparam logic [DIV_W-1:0] TERM    = DIV_W'(DIV_MAX);
   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (pause) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick    <= (div_cnt == TERM);
         div_cnt <= (div_cnt == TERM) ? '0 : div_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/pipe_sequencer.sv
// Four-phase pipeline sequencer (SCAN/ADV/WB/SETTLE) sharing one register-file port with debug scan.
// Advance one cycle after a free-run tick or step request; steps arriving mid-sequence are held pending.
module pipe_sequencer
   import pipe_pkg::*;
#(
   parameter int DIV_MAX = 63
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pause,
   input  logic       step_pulse,
   input  logic       wb_we,
   input  logic [3:0] wb_wa,
   input  logic [3:0] id_rs,
   output logic       adv,
   output logic       wr_window,
   output logic [3:0] rf_addr,
   output logic       rf_we,
   output logic [3:0] scan_addr,
   output logic       scan_valid,
   output logic       step_pend
);

   phase_t phase;
   logic   tick;
   logic   trigger;

   div_strobe #(
      .DIV_MAX (DIV_MAX)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .pause (pause),
      .tick  (tick)
   );

   assign trigger = pause ? (step_pulse || step_pend) : tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= PH_SCAN;
         scan_addr  <= 4'd0;
         step_pend  <= 1'b0;
         adv        <= 1'b0;
         wr_window  <= 1'b0;
         scan_valid <= 1'b1;
      end else begin
         if (phase == PH_SCAN) begin
            scan_addr <= scan_addr + 4'd1;
            if (trigger) begin
               phase      <= PH_ADV;
               adv        <= 1'b1;
               scan_valid <= 1'b0;
            end
         end else begin
            phase      <= seq_next(phase);
            adv        <= 1'b0;
            wr_window  <= (phase == PH_ADV);
            scan_valid <= (phase == PH_SETTLE);
         end

         // Any number of steps seen outside SCAN collapse into a single pending request.
         if (!pause)
            step_pend <= 1'b0;
         else if (phase == PH_SCAN && trigger)
            step_pend <= 1'b0;
         else if (step_pulse && phase != PH_SCAN)
            step_pend <= 1'b1;
      end
   end

   always_comb begin
      rf_addr = id_rs;
      rf_we   = 1'b0;
      case (phase)
         PH_SCAN: rf_addr = scan_addr;
         PH_WB: begin
            rf_we   = wb_we;
            rf_addr = wb_we ? wb_wa : id_rs;
         end
         default: rf_addr = id_rs;
      endcase
   end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed timing cases plus randomized traffic against a cycle-count reference model.
module tb_pipe_sequencer;

   localparam int DIV_MAX = 4;

   logic       clk;
   logic       rst_n;
   logic       pause;
   logic       step_pulse;
   logic       wb_we;
   logic [3:0] wb_wa;
   logic [3:0] id_rs;
   logic       adv;
   logic       wr_window;
   logic [3:0] rf_addr;
   logic       rf_we;
   logic [3:0] scan_addr;
   logic       scan_valid;
   logic       step_pend;

   pipe_sequencer #(.DIV_MAX(DIV_MAX)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pause      (pause),
      .step_pulse (step_pulse),
      .wb_we      (wb_we),
      .wb_wa      (wb_wa),
      .id_rs      (id_rs),
      .adv        (adv),
      .wr_window  (wr_window),
      .rf_addr    (rf_addr),
      .rf_we      (rf_we),
      .scan_addr  (scan_addr),
      .scan_valid (scan_valid),
      .step_pend  (step_pend)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: idle = in SCAN; pos = cycles since adv; run = consecutive free-run cycles so far.
   bit m_idle;
   int m_pos;
   bit m_pend;
   int m_scan;
   int m_run;

   logic       rec_adv  [64];
   logic       rec_wr   [64];
   logic       rec_sv   [64];
   logic       rec_pend [64];
   logic       rec_rfwe [64];
   logic [3:0] rec_scan [64];
   logic [3:0] rec_rfa  [64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic void reset_model();
      m_idle = 1'b1;
      m_pos  = 0;
      m_pend = 1'b0;
      m_scan = 0;
      m_run  = 0;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_adv"},   32'(adv),        32'd0);
      check({tag, "_wr"},    32'(wr_window),  32'd0);
      check({tag, "_rfwe"},  32'(rf_we),      32'd0);
      check({tag, "_sv"},    32'(scan_valid), 32'd1);
      check({tag, "_rfa"},   32'(rf_addr),    32'd0);
      check({tag, "_scan"},  32'(scan_addr),  32'd0);
      check({tag, "_pend"},  32'(step_pend),  32'd0);
   endtask

   // Called at a falling edge; leaves at the next falling edge.
   task automatic do_reset();
      rst_n      = 1'b0;
      pause      = 1'b1;
      step_pulse = 1'b0;
      wb_we      = 1'b1;
      wb_wa      = 4'd5;
      id_rs      = 4'd6;
      #1;
      check_reset_outputs("rst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      cyc = 0;
   endtask

   task automatic tick_cycle(input logic p, input logic sp, input logic we,
                             input logic [3:0] wa, input logic [3:0] rs);
      logic       trig;
      logic [3:0] e_rfa;
      pause      = p;
      step_pulse = sp;
      wb_we      = we;
      wb_wa      = wa;
      id_rs      = rs;
      #1;
      e_rfa = m_idle ? 4'(m_scan) : ((m_pos == 1 && we) ? wa : rs);
      check("adv",        32'(adv),        32'(!m_idle && m_pos == 0));
      check("wr_window",  32'(wr_window),  32'(!m_idle && m_pos == 1));
      check("scan_valid", 32'(scan_valid), 32'(m_idle));
      check("scan_addr",  32'(scan_addr),  32'(m_scan));
      check("step_pend",  32'(step_pend),  32'(m_pend));
      check("rf_we",      32'(rf_we),      32'(!m_idle && m_pos == 1 && we));
      check("rf_addr",    32'(rf_addr),    32'(e_rfa));
      if (cyc < 64) begin
         rec_adv[cyc]  = adv;
         rec_wr[cyc]   = wr_window;
         rec_sv[cyc]   = scan_valid;
         rec_pend[cyc] = step_pend;
         rec_rfwe[cyc] = rf_we;
         rec_scan[cyc] = scan_addr;
         rec_rfa[cyc]  = rf_addr;
      end
      trig = m_idle && (p ? (sp || m_pend) : (m_run > 0 && (m_run % (DIV_MAX + 1)) == 0));
      if (!p)                m_pend = 1'b0;
      else if (trig)         m_pend = 1'b0;
      else if (sp && !m_idle) m_pend = 1'b1;
      if (m_idle) begin
         m_scan = (m_scan + 1) % 16;
         if (trig) begin
            m_idle = 1'b0;
            m_pos  = 0;
         end
      end else if (m_pos == 2) begin
         m_idle = 1'b1;
      end else begin
         m_pos++;
      end
      m_run = p ? 0 : m_run + 1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      int  n;
      logic rp;
      rst_n      = 1'b0;
      pause      = 1'b1;
      step_pulse = 1'b0;
      wb_we      = 1'b0;
      wb_wa      = 4'd0;
      id_rs      = 4'd0;
      reset_model();
      @(negedge clk);

      // Free-run from reset: advances at 6, 11, 16.
      do_reset();
      for (int c = 0; c < 18; c++) tick_cycle(1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
      check("fr_adv6",  32'(rec_adv[6]),  32'd1);
      check("fr_adv11", 32'(rec_adv[11]), 32'd1);
      check("fr_adv16", 32'(rec_adv[16]), 32'd1);
      check("fr_wr7",   32'(rec_wr[7]),   32'd1);
      check("fr_wr17",  32'(rec_wr[17]),  32'd1);
      n = 0;
      for (int c = 0; c < 18; c++) n += int'(rec_adv[c]);
      check("fr_adv_count", 32'(n), 32'd3);

      // Single step at cycle 10.
      do_reset();
      for (int c = 0; c < 16; c++) tick_cycle(1'b1, c == 10, 1'b0, 4'd0, 4'd0);
      check("st_adv11", 32'(rec_adv[11]), 32'd1);
      check("st_wr12",  32'(rec_wr[12]),  32'd1);
      check("st_sv13",  32'(rec_sv[13]),  32'd0);
      check("st_sv14",  32'(rec_sv[14]),  32'd1);
      n = 0;
      for (int c = 0; c < 16; c++) n += int'(rec_adv[c]);
      check("st_adv_count", 32'(n), 32'd1);

      // Second step during WB is held pending and served from SCAN.
      do_reset();
      for (int c = 0; c < 21; c++) tick_cycle(1'b1, c == 10 || c == 12, 1'b0, 4'd0, 4'd0);
      check("pd_adv11",  32'(rec_adv[11]),  32'd1);
      check("pd_pend12", 32'(rec_pend[12]), 32'd0);
      check("pd_pend13", 32'(rec_pend[13]), 32'd1);
      check("pd_pend14", 32'(rec_pend[14]), 32'd1);
      check("pd_adv15",  32'(rec_adv[15]),  32'd1);
      check("pd_pend15", 32'(rec_pend[15]), 32'd0);
      n = 0;
      for (int c = 0; c < 21; c++) n += int'(rec_adv[c]);
      check("pd_adv_count", 32'(n), 32'd2);

      // Shared port muxing with and without a writeback.
      do_reset();
      for (int c = 0; c < 13; c++) tick_cycle(1'b1, c == 2 || c == 8, c < 7, 4'd7, 4'd3);
      check("rf_adv_a",   32'(rec_rfa[3]),  32'd3);
      check("rf_adv_we",  32'(rec_rfwe[3]), 32'd0);
      check("rf_wb_a",    32'(rec_rfa[4]),  32'd7);
      check("rf_wb_we",   32'(rec_rfwe[4]), 32'd1);
      check("rf_set_a",   32'(rec_rfa[5]),  32'd3);
      check("rf_set_we",  32'(rec_rfwe[5]), 32'd0);
      check("rf_nowb_a",  32'(rec_rfa[10]), 32'd3);
      check("rf_nowb_we", 32'(rec_rfwe[10]), 32'd0);

      // Scan index walks in SCAN and freezes during a sequence.
      do_reset();
      for (int c = 0; c < 26; c++) tick_cycle(1'b1, c == 20, 1'b0, 4'd0, 4'd0);
      for (int c = 0; c < 20; c++) check("scan_walk", 32'(rec_scan[c]), 32'(c % 16));
      for (int c = 21; c < 25; c++) check("scan_hold", 32'(rec_scan[c]), 32'd5);
      check("scan_resume", 32'(rec_scan[25]), 32'd6);

      // Step in first cycle after reset, then reset dropped in the middle of WB.
      do_reset();
      for (int c = 0; c < 2; c++) tick_cycle(1'b1, c == 0, 1'b1, 4'd9, 4'd2);
      check("first_step_adv1", 32'(rec_adv[1]), 32'd1);
      pause      = 1'b1;
      step_pulse = 1'b0;
      wb_we      = 1'b1;
      wb_wa      = 4'd9;
      id_rs      = 4'd2;
      #1;
      check("mid_wb_wr",  32'(wr_window), 32'd1);
      check("mid_wb_we",  32'(rf_we),     32'd1);
      check("mid_wb_rfa", 32'(rf_addr),   32'd9);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      cyc = 0;
      for (int c = 0; c < 10; c++) tick_cycle(1'b1, 1'b0, 1'b1, 4'd9, 4'd2);
      n = 0;
      for (int c = 0; c < 10; c++) n += int'(rec_adv[c]) + int'(rec_rfwe[c]);
      check("post_rst_quiet", 32'(n), 32'd0);

      // Randomized traffic.
      do_reset();
      rp = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(299, 0) == 0) begin
            do_reset();
            rp = 1'b1;
         end
         if ($urandom_range(15, 0) == 0) rp = ~rp;
         tick_cycle(rp, $urandom_range(4, 0) == 0, $urandom_range(1, 0) == 1,
                    4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
